otter_muldiv: RTL
=================

# otter_muldiv

Iterative multi-cycle multiply/divide unit implementing the RV32M operations for the OTTER core, and the sequential counterpart to the single-cycle ALU. Execute issues an operation with a start/ready handshake, and the unit answers with a one-cycle done pulse and a held result. Divide-by-zero and signed overflow resolve on a fast path. All other operations run a 32-step shift-add (multiply) or restoring (divide) loop.

## Interface
- Parameters: none (width fixed at 32).
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted on a rising edge when start && ready
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srcA  input  32  rs1 operand (multiplicand / dividend)
- srcB  input  32  rs2 operand (multiplier / divisor)
- kill  input  1  synchronous abort of the in-flight operation (pipeline flush)
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse: result valid
- result  output  32  result; held from the done cycle until the next accept

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - On accept, latch op and the operands.
  - Signed ops (MULH; DIV, REM): convert operands to magnitudes and record the result sign.
    - MULH and DIV: sign = sA ^ sB.
    - REM: sign = sA.
  - MULHSU: srcA is signed, srcB is unsigned.
  - Go to BUSY with the step counter at 0.
- Fast path: a divide op with srcB == 0, or DIV/REM with srcA == 0x80000000 and srcB == 0xFFFFFFFF, goes IDLE -> DONE directly.
  - DIV/DIVU by 0 -> 0xFFFFFFFF.
  - REM/REMU by 0 -> srcA.
  - Signed overflow: DIV -> 0x80000000, REM -> 0.
- BUSY, multiply:
  - 64-bit product register.
  - Each step adds the multiplicand if the current multiplier LSB is set, then shifts right.
- BUSY, divide:
  - Restoring division: shift the remainder left and bring in the next dividend bit.
  - Subtract the divisor if the remainder >= divisor; the quotient bit is 1 on subtract.
- BUSY exit: after step 31 go to DONE.
  - Apply the sign: two's-complement negate of the 64-bit product or of the quotient/remainder when the sign flag is set.
  - Select the output: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
- DONE: done = 1 for one cycle, then IDLE. result stays held.
- kill:
  - In BUSY or DONE: next state IDLE, no done pulse, result unchanged.
  - kill in the same cycle as the DONE transition: kill wins.
  - kill in IDLE: ignored, and a simultaneous start is still accepted.
- start while ready = 0: ignored, not queued.
- Operand inputs are don't-care except in the accept cycle.

## Timing
- Reset values: ready = 1, done = 0, result = 0x00000000, state IDLE, counter 0.
- rst_n low at any time, including mid-BUSY: immediate return to reset values; the operation is lost.
- Latency, with k = accept cycle:
  - Normal op: done high in cycle k+33.
  - Fast path: done high in cycle k+1.
- ready is low from k+1 through the done cycle inclusive; the earliest next accept is the cycle after done.
- Back-to-back: throughput is 1 op per 34 cycles (normal) or per 2 cycles (fast path).
- All arithmetic is modulo 2^32 (2^64 for the product). No exceptions or flags are raised.

## Configuration
- OTTER_MULDIV_FAST_MUL_EN:
  - Defined: all four multiply ops use a single combinational 32x32 -> 64 multiplier. They take the fast path, with done in cycle k+1, and the shift-add datapath is removed. Divide is unchanged.
  - Undefined: the multiply timing in Timing applies.

## Test plan
- MUL 7 x 0xFFFFFFFD (-3): result 0xFFFFFFEB, done in cycle k+33, ready low k+1..k+33.
- MULH 0x80000000 x 0x80000000: result 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF: result 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2: result 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2: result 0xFFFFFFFD. REM -7 / 2: result 0xFFFFFFFF. DIVU 100 / 7: result 14. REMU 100 / 7: result 2.
- DIVU 5 / 0: result 0xFFFFFFFF. REMU 5 / 0: result 5. DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM of the same operands: result 0. All four: done in cycle k+1.
- kill asserted at k+10 of a MUL: no done pulse, ready high at k+11, result keeps its previous value. A start held across the kill is accepted at k+11.
- rst_n pulsed low mid-BUSY: ready = 1, done = 0, result = 0 immediately. The next op completes with the correct value.

Source files
------------

// File: rtl/otter_muldiv_if.sv
// Execute-stage handshake bundle for the iterative RV32M multiply/divide unit.
interface otter_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        kill;
  logic        ready;
  logic        done;
  logic [31:0] result;

  modport master (output start, op, srcA, srcB, kill, input ready, done, result);
  modport slave  (input start, op, srcA, srcB, kill, output ready, done, result);
endinterface

// File: rtl/otter_muldiv.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply, restoring divide, fast path for div-by-0/overflow.
// Optional OTTER_MULDIV_FAST_MUL_EN: single-cycle combinational multiplier for all multiply ops.
module otter_muldiv (
  input  logic          clk,
  input  logic          rst_n,
  otter_muldiv_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sign_q, sign_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              signed_a, signed_b, a_s, b_s, in_sign, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_next, step_next;
  logic [XLEN-1:0]   fin_quo, fin_rem;
  logic [2*XLEN-1:0] fin_prod;
`ifdef OTTER_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`else
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
`endif

  function automatic logic [XLEN-1:0] pick(input logic [2:0] f, input logic [2*XLEN-1:0] p,
                                           input logic [XLEN-1:0] q, input logic [XLEN-1:0] r);
    case (f)
      3'b000:                pick = p[XLEN-1:0];
      3'b001, 3'b010, 3'b011: pick = p[2*XLEN-1:XLEN];
      3'b100, 3'b101:        pick = q;
      default:               pick = r;
    endcase
  endfunction

  // Operand conditioning for the accept cycle
  always_comb begin
    signed_a = bus.op[2] ? !bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10);
    signed_b = (bus.op == 3'b001) || (bus.op[2] && !bus.op[0]);
    a_s      = signed_a && bus.srcA[XLEN-1];
    b_s      = signed_b && bus.srcB[XLEN-1];
    a_mag    = a_s ? XLEN'(~bus.srcA + 32'd1) : bus.srcA;
    b_mag    = b_s ? XLEN'(~bus.srcB + 32'd1) : bus.srcB;
    case (bus.op)
      3'b001, 3'b100: in_sign = a_s ^ b_s;
      3'b010, 3'b110: in_sign = a_s;
      default:        in_sign = 1'b0;
    endcase
    div_zero = bus.op[2] && (bus.srcB == '0);
    div_ovf  = bus.op[2] && !bus.op[0] && (bus.srcA == 32'h8000_0000) && (bus.srcB == '1);
  end

  // One iteration of the datapath; remainder lives in acc[63:32], dividend/quotient in acc[31:0]
  always_comb begin
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge   = rem_sh >= {1'b0, b_q};
    rem_new  = rem_ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0];
    div_next = {rem_new, acc_q[XLEN-2:0], rem_ge};
`ifdef OTTER_MULDIV_FAST_MUL_EN
    fast_a    = {{XLEN{a_s}}, bus.srcA};
    fast_b    = {{XLEN{b_s}}, bus.srcB};
    fast_prod = 64'(fast_a * fast_b);
    step_next = div_next;
    fin_prod  = '0;
`else
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    step_next = op_q[2] ? div_next : mul_next;
    fin_prod  = sign_q ? 64'(~step_next + 64'd1) : step_next;
`endif
    fin_quo = sign_q ? XLEN'(~step_next[XLEN-1:0] + 32'd1) : step_next[XLEN-1:0];
    fin_rem = sign_q ? XLEN'(~step_next[2*XLEN-1:XLEN] + 32'd1) : step_next[2*XLEN-1:XLEN];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          sign_d = in_sign;
          cnt_d  = '0;
          if (div_zero) begin
            result_d = bus.op[1] ? bus.srcA : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = bus.op[1] ? '0 : 32'h8000_0000;
            state_d  = DONE;
`ifdef OTTER_MULDIV_FAST_MUL_EN
          end else if (!bus.op[2]) begin
            result_d = pick(bus.op, fast_prod, '0, '0);
            state_d  = DONE;
`endif
          end else begin
            state_d = BUSY;
            acc_d   = {{XLEN{1'b0}}, bus.op[2] ? a_mag : b_mag};
            b_d     = bus.op[2] ? b_mag : a_mag;
          end
        end
      end
      BUSY: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = CW'(cnt_q + 5'd1);
          if (cnt_q == 5'd31) begin
            state_d  = DONE;
            result_d = pick(op_q, fin_prod, fin_quo, fin_rem);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_q   <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
